// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared state, pc-select and redirect-winner encodings for the pipeline controller
package pipe_ctrl_pkg;

  typedef enum logic [2:0] {
    STATE_RUN        = 3'd0,
    STATE_LOAD_STALL = 3'd1,
    STATE_JALR_WAIT  = 3'd2,
    STATE_RET_WAIT   = 3'd3,
    STATE_HALT       = 3'd4
  } ctrl_state_t;

  localparam logic [1:0] PC_SEL_PREDICT = 2'd0;
  localparam logic [1:0] PC_SEL_E       = 2'd1;
  localparam logic [1:0] PC_SEL_M       = 2'd2;
  localparam logic [1:0] PC_SEL_W       = 2'd3;

  // Ordered oldest-first; WIN_NONE means no source is active.
  typedef enum logic [2:0] {
    WIN_NONE       = 3'd0,
    WIN_HALT       = 3'd1,
    WIN_RET_VALID  = 3'd2,
    WIN_MISPREDICT = 3'd3,
    WIN_JALR_VALID = 3'd4,
    WIN_LOAD_USE   = 3'd5,
    WIN_RET        = 3'd6,
    WIN_JALR       = 3'd7
  } redirect_win_t;

  function automatic logic [3:0] wait_load(input int unsigned cycles);
    return 4'(cycles - 1);
  endfunction

endpackage

// File: rtl/redirect_priority.sv
// rtl/redirect_priority.sv - combinational oldest-first encoder of redirect/hazard sources
import pipe_ctrl_pkg::*;

module redirect_priority (
  input  logic          halt,
  input  logic          ret_valid,
  input  logic          mispredict,
  input  logic          jalr_valid,
  input  logic          load_use,
  input  logic          ret,
  input  logic          jalr,
  output logic [1:0]    pc_select,
  output redirect_win_t winner
);

  always_comb begin
    pc_select = PC_SEL_PREDICT;
    winner    = WIN_NONE;
    if (halt) begin
      winner = WIN_HALT;
    end else if (ret_valid) begin
      winner    = WIN_RET_VALID;
      pc_select = PC_SEL_W;
    end else if (mispredict) begin
      winner    = WIN_MISPREDICT;
      pc_select = PC_SEL_M;
    end else if (jalr_valid) begin
      winner    = WIN_JALR_VALID;
      pc_select = PC_SEL_E;
    end else if (load_use) begin
      winner = WIN_LOAD_USE;
    end else if (ret) begin
      winner = WIN_RET;
    end else if (jalr) begin
      winner = WIN_JALR;
    end
  end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// rtl/pipeline_hazard_controller.sv - pipeline sequencer FSM; PIPE_CTRL_PERF_EN adds stall/flush counters
import pipe_ctrl_pkg::*;

module pipeline_hazard_controller #(
  parameter int unsigned RET_WAIT_CYCLES  = 3,
  parameter int unsigned JALR_WAIT_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       d_jalr,
  input  logic       d_ret,
  input  logic       e_load_use,
  input  logic       e_jalr_valid,
  input  logic       m_mispredict,
  input  logic       w_ret_valid,
  input  logic       w_halt,
  output logic [1:0] pc_select,
  output logic       f_stall,
  output logic       d_stall,
  output logic       d_bubble,
  output logic       e_bubble,
  output logic       m_bubble,
  output logic       halted,
  output logic [2:0] state
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_flush_events
`endif
);

  localparam logic [3:0] RET_LOAD  = wait_load(RET_WAIT_CYCLES);
  localparam logic [3:0] JALR_LOAD = wait_load(JALR_WAIT_CYCLES);

  ctrl_state_t   state_q, next_state;
  logic [3:0]    cnt_q, next_cnt;
  logic [1:0]    win_pc;
  redirect_win_t winner;
  logic          in_run;

  assign in_run = (state_q == STATE_RUN);

  // Wait-completion sources only count while their wait state is active.
  redirect_priority u_redirect_priority (
    .halt       (w_halt),
    .ret_valid  (w_ret_valid && (state_q == STATE_RET_WAIT)),
    .mispredict (m_mispredict),
    .jalr_valid (e_jalr_valid && (state_q == STATE_JALR_WAIT)),
    .load_use   (e_load_use && in_run),
    .ret        (d_ret && in_run),
    .jalr       (d_jalr && in_run),
    .pc_select  (win_pc),
    .winner     (winner)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= STATE_RUN;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= next_state;
      cnt_q   <= next_cnt;
    end
  end

  always_comb begin
    next_state = state_q;
    next_cnt   = cnt_q;
    pc_select  = PC_SEL_PREDICT;
    f_stall    = 1'b0;
    d_stall    = 1'b0;
    d_bubble   = 1'b0;
    e_bubble   = 1'b0;
    m_bubble   = 1'b0;
    halted     = 1'b0;

    if (state_q == STATE_HALT) begin
      f_stall  = 1'b1;
      d_stall  = 1'b1;
      d_bubble = 1'b1;
      e_bubble = 1'b1;
      m_bubble = 1'b1;
      halted   = 1'b1;
      next_cnt = 4'd0;
    end else begin
      pc_select = win_pc;
      if ((state_q == STATE_JALR_WAIT) || (state_q == STATE_RET_WAIT)) begin
        f_stall  = 1'b1;
        d_bubble = 1'b1;
        next_cnt = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
      end
      case (winner)
        WIN_HALT: begin
          f_stall    = 1'b1;
          d_stall    = 1'b1;
          d_bubble   = 1'b1;
          e_bubble   = 1'b1;
          m_bubble   = 1'b1;
          next_state = STATE_HALT;
          next_cnt   = 4'd0;
        end
        WIN_RET_VALID, WIN_JALR_VALID: begin
          f_stall    = 1'b0;
          next_state = STATE_RUN;
          next_cnt   = 4'd0;
        end
        // Fetch must follow the redirect, so any wait-state stall is dropped.
        WIN_MISPREDICT: begin
          f_stall    = 1'b0;
          d_bubble   = 1'b1;
          e_bubble   = 1'b1;
          next_state = STATE_RUN;
          next_cnt   = 4'd0;
        end
        WIN_LOAD_USE: begin
          f_stall    = 1'b1;
          d_stall    = 1'b1;
          d_bubble   = 1'b1;
          next_state = STATE_LOAD_STALL;
        end
        WIN_RET: begin
          f_stall    = 1'b1;
          next_cnt   = RET_LOAD;
          next_state = STATE_RET_WAIT;
        end
        WIN_JALR: begin
          f_stall    = 1'b1;
          next_cnt   = JALR_LOAD;
          next_state = STATE_JALR_WAIT;
        end
        default: begin
          if (state_q == STATE_LOAD_STALL) next_state = STATE_RUN;
        end
      endcase
    end

    if (reset) begin
      pc_select = PC_SEL_PREDICT;
      f_stall   = 1'b0;
      d_stall   = 1'b0;
      d_bubble  = 1'b1;
      e_bubble  = 1'b1;
      m_bubble  = 1'b1;
      halted    = 1'b0;
    end
  end

  assign state = state_q;

`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_stall_cycles <= 32'd0;
      perf_flush_events <= 32'd0;
    end else if (state_q != STATE_HALT) begin
      if (f_stall) perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (winner == WIN_MISPREDICT) perf_flush_events <= perf_flush_events + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb/tb_pipeline_hazard_controller.sv - directed self-checking bench for pipeline_hazard_controller
module tb_pipeline_hazard_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       d_jalr, d_ret, e_load_use, e_jalr_valid, m_mispredict, w_ret_valid, w_halt;
  logic [1:0] pc_select;
  logic       f_stall, d_stall, d_bubble, e_bubble, m_bubble, halted;
  logic [2:0] state;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_cycles, perf_flush_events;
`endif

  int checks = 0;
  int failures = 0;

  pipeline_hazard_controller #(
    .RET_WAIT_CYCLES  (3),
    .JALR_WAIT_CYCLES (1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .d_jalr       (d_jalr),
    .d_ret        (d_ret),
    .e_load_use   (e_load_use),
    .e_jalr_valid (e_jalr_valid),
    .m_mispredict (m_mispredict),
    .w_ret_valid  (w_ret_valid),
    .w_halt       (w_halt),
    .pc_select    (pc_select),
    .f_stall      (f_stall),
    .d_stall      (d_stall),
    .d_bubble     (d_bubble),
    .e_bubble     (e_bubble),
    .m_bubble     (m_bubble),
    .halted       (halted),
    .state        (state)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_flush_events (perf_flush_events)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    {d_jalr, d_ret, e_load_use, e_jalr_valid, m_mispredict, w_ret_valid, w_halt} = 7'd0;
  endtask

  task automatic check_ctrl(input string tag, input logic [1:0] pc, input logic fs, input logic ds,
                            input logic [2:0] bub, input logic hl);
    check({tag, "_pc"}, 32'(pc_select), 32'(pc));
    check({tag, "_f_stall"}, 32'(f_stall), 32'(fs));
    check({tag, "_d_stall"}, 32'(d_stall), 32'(ds));
    check({tag, "_bubbles"}, 32'({d_bubble, e_bubble, m_bubble}), 32'(bub));
    check({tag, "_halted"}, 32'(halted), 32'(hl));
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    #2;
    check("rst_state", 32'(state), 32'd0);
    check_ctrl("rst", 2'd0, 1'b0, 1'b0, 3'b111, 1'b0);
    tick();
    reset = 1'b0;
    #1;
    check_ctrl("run_idle", 2'd0, 1'b0, 1'b0, 3'b000, 1'b0);

    // load-use: one stall cycle, one LOAD_STALL cycle, back to RUN
    e_load_use = 1'b1;
    #1 check_ctrl("lu0", 2'd0, 1'b1, 1'b1, 3'b100, 1'b0);
    tick();
    e_load_use = 1'b0;
    #1 check("lu1_state", 32'(state), 32'd1);
    check_ctrl("lu1", 2'd0, 1'b0, 1'b0, 3'b000, 1'b0);
    tick();
    check("lu2_state", 32'(state), 32'd0);
    check("lu2_pc", 32'(pc_select), 32'd0);

    // ret with target arriving on the third cycle
    d_ret = 1'b1;
    #1 check("ret0_f_stall", 32'(f_stall), 32'd1);
    tick();
    d_ret = 1'b0;
    #1 check("ret1_state", 32'(state), 32'd3);
    check("ret1_f_stall", 32'(f_stall), 32'd1);
    tick();
    w_ret_valid = 1'b1;
    #1 check("ret2_pc", 32'(pc_select), 32'd3);
    check("ret2_f_stall", 32'(f_stall), 32'd0);
    tick();
    w_ret_valid = 1'b0;
    #1 check("ret3_state", 32'(state), 32'd0);

    // mispredict beats jalr completion in JALR_WAIT
    d_jalr = 1'b1;
    tick();
    d_jalr = 1'b0;
    #1 check("jm_state", 32'(state), 32'd2);
    e_jalr_valid = 1'b1;
    m_mispredict = 1'b1;
    #1 check("jm_pc", 32'(pc_select), 32'd2);
    check("jm_bub", 32'({d_bubble, e_bubble}), 32'b11);
    tick();
    idle_inputs();
    #1 check("jm_next_state", 32'(state), 32'd0);

    // async reset in RET_WAIT with counter=2
    d_ret = 1'b1;
    tick();
    d_ret = 1'b0;
    #1 check("rr_state_pre", 32'(state), 32'd3);
    reset = 1'b1;
    #1 check("rr_state", 32'(state), 32'd0);
    check_ctrl("rr", 2'd0, 1'b0, 1'b0, 3'b111, 1'b0);
    tick();
    reset = 1'b0;
    #1 check_ctrl("rr_post", 2'd0, 1'b0, 1'b0, 3'b000, 1'b0);

    // three load-use stalls then two mispredicts
    for (int i = 0; i < 3; i++) begin
      e_load_use = 1'b1;
      tick();
      e_load_use = 1'b0;
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      m_mispredict = 1'b1;
      #1 check("mp_pc", 32'(pc_select), 32'd2);
      tick();
      m_mispredict = 1'b0;
    end
    #1;
`ifdef PIPE_CTRL_PERF_EN
    check("perf_stall_a", perf_stall_cycles, 32'd3);
    check("perf_flush_a", perf_flush_events, 32'd2);
`endif

    // jalr target late: counter saturates at 0 and state holds
    d_jalr = 1'b1;
    #1 check("jh0_f_stall", 32'(f_stall), 32'd1);
    tick();
    d_jalr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 check("jh_state", 32'(state), 32'd2);
      check("jh_f_stall", 32'(f_stall), 32'd1);
      check("jh_d_bubble", 32'(d_bubble), 32'd1);
      tick();
    end
    e_jalr_valid = 1'b1;
    #1 check("jh_pc", 32'(pc_select), 32'd1);
    check("jh_f_stall_rel", 32'(f_stall), 32'd0);
    tick();
    e_jalr_valid = 1'b0;
    #1 check("jh_done_state", 32'(state), 32'd0);

    // halt wins over mispredict and is absorbing
    m_mispredict = 1'b1;
    w_halt = 1'b1;
    #1 check_ctrl("hlt0", 2'd0, 1'b1, 1'b1, 3'b111, 1'b0);
    tick();
    for (int i = 0; i < 10; i++) begin
      {d_jalr, d_ret, e_load_use, e_jalr_valid, m_mispredict, w_ret_valid, w_halt} = 7'($urandom);
      #1 check("hlt_state", 32'(state), 32'd4);
      check_ctrl("hlt", 2'd0, 1'b1, 1'b1, 3'b111, 1'b1);
      tick();
    end
`ifdef PIPE_CTRL_PERF_EN
    check("perf_stall_frozen", perf_stall_cycles, 32'd8);
    check("perf_flush_frozen", perf_flush_events, 32'd2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
- Central sequencer for the 5-stage RISC-V pipeline (F/D, E, M, W).
- Owns the fetch PC-source select and the per-stage stall/bubble controls.
- Resolves load-use hazards, jalr target waits, branch mispredicts, ret redirects and halt.
- Replaces ad-hoc redirect muxing inside the fetch/decode stage with one prioritised FSM.

Parameters:
- RET_WAIT_CYCLES, 3, cycles from ret decode in D until its target is valid in W; legal range 1..15.
- JALR_WAIT_CYCLES, 1, cycles from jalr decode in D until its target is valid in E; legal range 1..3.

Ports:
- clk  input  1  pipeline clock, all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- d_jalr  input  1  jalr decoded in D this cycle.
- d_ret  input  1  ret decoded in D this cycle.
- e_load_use  input  1  E holds a load whose rd matches rs1/rs2 of D (rd != x0).
- e_jalr_valid  input  1  jalr target valid in E.
- m_mispredict  input  1  conditional branch in M resolved opposite to prediction.
- w_ret_valid  input  1  ret target valid in W.
- w_halt  input  1  ecall/ebreak retiring in W.
- pc_select  output  2  0=predict_pc, 1=stage_e_pc, 2=stage_m_pc, 3=stage_w_pc.
- f_stall  output  1  hold fetch PC register.
- d_stall  output  1  hold F/D output register.
- d_bubble  output  1  insert NOP into D/E register.
- e_bubble  output  1  insert NOP into E/M register.
- m_bubble  output  1  insert NOP into M/W register.
- halted  output  1  pipeline frozen after halt.
- state  output  3  current FSM state, for debug.

Behaviour:
- States: RUN=0, LOAD_STALL=1, JALR_WAIT=2, RET_WAIT=3, HALT=4. Reset → RUN, wait counter 0.
- While reset is high: pc_select=0, f_stall=0, d_stall=0, d_bubble=e_bubble=m_bubble=1, halted=0.
- Outputs are combinational from state and inputs. State and 4-bit wait counter are registered.
- Redirect priority is oldest-first:
  - w_halt > w_ret_valid (in RET_WAIT) > m_mispredict > e_jalr_valid (in JALR_WAIT) > e_load_use > d_ret > d_jalr.
- Any state, w_halt=1: next state HALT. Same cycle f_stall=d_stall=1, d_bubble=e_bubble=m_bubble=1.
- HALT: absorbing until reset. Drives f_stall=d_stall=1, all bubbles 1, halted=1, pc_select=0.
- Any non-HALT state, m_mispredict=1 (no halt):
  - pc_select=2, d_bubble=e_bubble=1.
  - Next state RUN, counter cleared. This aborts LOAD_STALL, JALR_WAIT and RET_WAIT, since the younger instruction is squashed.
- RUN:
  - e_load_use=1: f_stall=d_stall=1, d_bubble=1, next LOAD_STALL.
  - Else d_ret=1: f_stall=1, counter←RET_WAIT_CYCLES-1, next RET_WAIT.
  - Else d_jalr=1: f_stall=1, counter←JALR_WAIT_CYCLES-1, next JALR_WAIT.
  - Else pc_select=0, no stalls or bubbles.
- LOAD_STALL: exactly one cycle, no controls asserted; next RUN. d_ret/d_jalr are re-evaluated on the following RUN cycle.
- JALR_WAIT:
  - Each cycle: f_stall=1, d_bubble=1, counter decrements.
  - e_jalr_valid=1: pc_select=1, f_stall=0, next RUN.
  - Counter at 0 without e_jalr_valid: remain in state, counter holds at 0.
- RET_WAIT:
  - Same pattern as JALR_WAIT, using w_ret_valid and pc_select=3.
- Counter never wraps below 0.

Optional Feature:
- Macro PIPE_CTRL_PERF_EN.
- Defined: adds outputs perf_stall_cycles[31:0] (cycles with f_stall=1 outside HALT) and perf_flush_events[31:0] (cycles with m_mispredict honoured).
  - Both reset to 0, wrap modulo 2^32, and freeze in HALT.
- Undefined: ports absent, no counter flops.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - state encodings STATE_RUN..STATE_HALT;
  - PC_SEL_PREDICT/E/M/W constants (0..3);
  - shared by fetch_decode and this block.
- One natural sub-module: redirect_priority, a combinational priority encoder mapping the valid redirect sources to pc_select plus a winner-id. The FSM stays in the top module.

Test Plan:
- Reset asserted mid-RET_WAIT with counter=2 → immediately state=0, all bubbles=1, pc_select=0. After release, first cycle has no stalls.
- RUN, e_load_use=1 for one cycle → f_stall=d_stall=d_bubble=1 that cycle, state=1 next, state=0 the cycle after, pc_select=0 throughout.
- RUN, d_ret=1, RET_WAIT_CYCLES=3, w_ret_valid=1 on the third cycle → f_stall=1 for 2 cycles then pc_select=3, f_stall=0, state returns to 0.
- In JALR_WAIT, m_mispredict=1 and e_jalr_valid=1 same cycle → pc_select=2, d_bubble=e_bubble=1, next state RUN (mispredict wins).
- m_mispredict=1 and w_halt=1 same cycle → state=4 next, halted=1, pc_select=0, all stalls and bubbles held high for 10 further cycles regardless of inputs.
- With PIPE_CTRL_PERF_EN: 3 load-use stalls + 2 mispredicts → perf_stall_cycles=3, perf_flush_events=2.
